// File: rtl/rtc_calendar_counter_if.sv
// Control, load and status bundle for the RTC calendar counter.
// The master side drives run/load requests; the slave side returns time and date.
interface rtc_calendar_counter_if;
    logic       run;
    logic       set_time;
    logic       set_date;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic [6:0] set_year;
    logic [3:0] set_month;
    logic [4:0] set_day;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic       day_wrap;
    logic       load_err;

    modport master (
        output run, set_time, set_date,
        output set_hours, set_minutes, set_seconds,
        output set_year, set_month, set_day,
        input  hours, minutes, seconds,
        input  year, month, day,
        input  day_wrap, load_err
    );

    modport slave (
        input  run, set_time, set_date,
        input  set_hours, set_minutes, set_seconds,
        input  set_year, set_month, set_day,
        output hours, minutes, seconds,
        output year, month, day,
        output day_wrap, load_err
    );
endinterface

// File: rtl/rtc_calendar_counter.sv
// Time-of-day and calendar counter stepped by clk_1Hz, with validated loads.
// Define RTC_LEAP_YEAR_EN to give February 29 days when year[1:0]==0.
module rtc_calendar_counter #(
    parameter int unsigned RST_HOUR  = 0,
    parameter int unsigned RST_MIN   = 0,
    parameter int unsigned RST_SEC   = 0,
    parameter int unsigned RST_YEAR  = 24,
    parameter int unsigned RST_MONTH = 1,
    parameter int unsigned RST_DAY   = 1
) (
    input  logic                   clk_1Hz,
    input  logic                   rst,
    rtc_calendar_counter_if.slave  bus
);

    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic [6:0] year_q, year_d;
    logic [3:0] month_q, month_d;
    logic [4:0] day_q, day_d;
    logic       wrap_q, wrap_d;
    logic       err_q, err_d;

    logic       leap_cur, leap_set;
    logic [4:0] cur_len, set_len;
    logic       time_valid, date_valid;
    logic       t_ok, d_ok;
    logic       sec_end, min_end, hr_end;
    logic       day_carry;

    function automatic logic [4:0] month_len(input logic [3:0] mo, input logic leap);
        logic [4:0] len;
        case (mo)
            4'd2:                       len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:    len = 5'd30;
            default:                    len = 5'd31;
        endcase
        return len;
    endfunction

`ifdef RTC_LEAP_YEAR_EN
    assign leap_cur = (year_q[1:0] == 2'b00);
    assign leap_set = (bus.set_year[1:0] == 2'b00);
`else
    assign leap_cur = 1'b0;
    assign leap_set = 1'b0;
`endif

    assign cur_len = month_len(month_q, leap_cur);
    assign set_len = month_len(bus.set_month, leap_set);

    assign time_valid = (bus.set_hours <= 5'd23) &&
                        (bus.set_minutes <= 6'd59) &&
                        (bus.set_seconds <= 6'd59);

    assign date_valid = (bus.set_year <= 7'd99) &&
                        (bus.set_month >= 4'd1) && (bus.set_month <= 4'd12) &&
                        (bus.set_day >= 5'd1) && (bus.set_day <= set_len);

    assign t_ok = bus.set_time && time_valid;
    assign d_ok = bus.set_date && date_valid;

    assign sec_end = (seconds_q == 6'd59);
    assign min_end = (minutes_q == 6'd59);
    assign hr_end  = (hours_q == 5'd23);

    // A valid time load freezes the date, so it also suppresses the day carry.
    assign day_carry = bus.run && !t_ok && sec_end && min_end && hr_end;

    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        year_d    = year_q;
        month_d   = month_q;
        day_d     = day_q;
        wrap_d    = day_carry;
        err_d     = (bus.set_time && !time_valid) ||
                    (bus.set_date && !date_valid);

        if (t_ok) begin
            hours_d   = bus.set_hours;
            minutes_d = bus.set_minutes;
            seconds_d = bus.set_seconds;
        end else if (bus.run) begin
            if (sec_end) begin
                seconds_d = 6'd0;
                if (min_end) begin
                    minutes_d = 6'd0;
                    hours_d   = hr_end ? 5'd0 : hours_q + 5'd1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end

        // A loaded date wins over any carry out of the time chain.
        if (d_ok) begin
            year_d  = bus.set_year;
            month_d = bus.set_month;
            day_d   = bus.set_day;
        end else if (day_carry) begin
            if (day_q >= cur_len) begin
                day_d = 5'd1;
                if (month_q >= 4'd12) begin
                    month_d = 4'd1;
                    year_d  = (year_q >= 7'd99) ? 7'd0 : year_q + 7'd1;
                end else begin
                    month_d = month_q + 4'd1;
                end
            end else begin
                day_d = day_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            hours_q   <= 5'(RST_HOUR);
            minutes_q <= 6'(RST_MIN);
            seconds_q <= 6'(RST_SEC);
            year_q    <= 7'(RST_YEAR);
            month_q   <= 4'(RST_MONTH);
            day_q     <= 5'(RST_DAY);
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            year_q    <= year_d;
            month_q   <= month_d;
            day_q     <= day_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    assign bus.hours    = hours_q;
    assign bus.minutes  = minutes_q;
    assign bus.seconds  = seconds_q;
    assign bus.year     = year_q;
    assign bus.month    = month_q;
    assign bus.day      = day_q;
    assign bus.day_wrap = wrap_q;
    assign bus.load_err = err_q;

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Bench for rtc_calendar_counter: directed vector table, async reset, then
// random traffic against a seconds-of-day / calendar arithmetic model.
module tb_rtc_calendar_counter;

    typedef struct {
        bit run, st, sd;
        int sh, smi, ss, sy, smo, sdy;
        int eh, emi, es, ey, emo, edy;
        bit ew, ee;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rtc_calendar_counter_if bus ();

    rtc_calendar_counter dut (
        .clk_1Hz (clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int mh, mm, ms, my, mmo, md;
    bit mw, me;

    function automatic int mlen(int mo, int yr);
        if (mo == 2) begin
`ifdef RTC_LEAP_YEAR_EN
            return (yr % 4 == 0) ? 29 : 28;
`else
            return (yr < 0) ? 0 : 28;
`endif
        end
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic vec_t mk(bit run, bit st, bit sd,
                                int sh, int smi, int ss,
                                int sy, int smo, int sdy,
                                int eh, int emi, int es,
                                int ey, int emo, int edy,
                                bit ew, bit ee);
        vec_t v;
        v.run = run; v.st = st; v.sd = sd;
        v.sh = sh; v.smi = smi; v.ss = ss;
        v.sy = sy; v.smo = smo; v.sdy = sdy;
        v.eh = eh; v.emi = emi; v.es = es;
        v.ey = ey; v.emo = emo; v.edy = edy;
        v.ew = ew; v.ee = ee;
        return v;
    endfunction

    task automatic drive(bit run, bit st, bit sd,
                         int sh, int smi, int ss,
                         int sy, int smo, int sdy);
        bus.run         = run;
        bus.set_time    = st;
        bus.set_date    = sd;
        bus.set_hours   = 5'(sh);
        bus.set_minutes = 6'(smi);
        bus.set_seconds = 6'(ss);
        bus.set_year    = 7'(sy);
        bus.set_month   = 4'(smo);
        bus.set_day     = 5'(sdy);
    endtask

    task automatic check(string name,
                         int eh, int emi, int es,
                         int ey, int emo, int edy,
                         bit ew, bit ee);
        logic [34:0] got, exp;
        got = {bus.hours, bus.minutes, bus.seconds,
               bus.year, bus.month, bus.day,
               bus.day_wrap, bus.load_err};
        exp = {5'(eh), 6'(emi), 6'(es), 7'(ey), 4'(emo), 5'(edy), ew, ee};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d:%0d %0d-%0d-%0d wrap=%0b err=%0b, want %0d:%0d:%0d %0d-%0d-%0d wrap=%0b err=%0b",
                     name, bus.hours, bus.minutes, bus.seconds,
                     bus.year, bus.month, bus.day, bus.day_wrap, bus.load_err,
                     eh, emi, es, ey, emo, edy, ew, ee);
        end
    endtask

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0;
        my = 24; mmo = 1; md = 1;
        mw = 0; me = 0;
    endtask

    task automatic model_step(bit run, bit st, bit sd,
                              int sh, int smi, int ss,
                              int sy, int smo, int sdy);
        bit tv, dv, tok, dok, carry;
        int tsec;
        tv = (sh <= 23) && (smi <= 59) && (ss <= 59);
        dv = (sy <= 99) && (smo >= 1) && (smo <= 12) &&
             (sdy >= 1) && (sdy <= mlen(smo, sy));
        tok = st && tv;
        dok = sd && dv;
        me = (st && !tv) || (sd && !dv);
        tsec = mh * 3600 + mm * 60 + ms;
        carry = run && !tok && (tsec == 86399);
        mw = carry;
        if (tok) begin
            mh = sh; mm = smi; ms = ss;
        end else if (run) begin
            tsec = (tsec + 1) % 86400;
            mh = tsec / 3600;
            mm = (tsec / 60) % 60;
            ms = tsec % 60;
        end
        if (dok) begin
            my = sy; mmo = smo; md = sdy;
        end else if (carry) begin
            md++;
            if (md > mlen(mmo, my)) begin
                md = 1;
                mmo++;
                if (mmo > 12) begin
                    mmo = 1;
                    my = (my + 1) % 100;
                end
            end
        end
    endtask

    initial begin
        vec_t tv[$];
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);

        #12;
        check("reset_state", 0, 0, 0, 24, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        tv.push_back(mk(1,0,0, 0,0,0, 0,1,1,   0,0,1, 24,1,1, 0,0));
        tv.push_back(mk(1,0,0, 0,0,0, 0,1,1,   0,0,2, 24,1,1, 0,0));
        tv.push_back(mk(1,0,0, 0,0,0, 0,1,1,   0,0,3, 24,1,1, 0,0));
        tv.push_back(mk(1,1,1, 23,59,59, 24,2,28,  23,59,59, 24,2,28, 0,0));
`ifdef RTC_LEAP_YEAR_EN
        tv.push_back(mk(1,0,0, 0,0,0, 0,1,1,   0,0,0, 24,2,29, 1,0));
`else
        tv.push_back(mk(1,0,0, 0,0,0, 0,1,1,   0,0,0, 24,3,1, 1,0));
`endif
        tv.push_back(mk(1,1,1, 23,59,59, 99,12,31,  23,59,59, 99,12,31, 0,0));
        tv.push_back(mk(1,0,0, 0,0,0, 0,1,1,   0,0,0, 0,1,1, 1,0));
        tv.push_back(mk(1,0,0, 0,0,0, 0,1,1,   0,0,1, 0,1,1, 0,0));
        tv.push_back(mk(1,1,0, 24,0,0, 0,1,1,  0,0,2, 0,1,1, 0,1));
        tv.push_back(mk(1,0,1, 0,0,0, 24,4,31, 0,0,3, 0,1,1, 0,1));
        tv.push_back(mk(1,1,1, 12,34,56, 25,6,15, 12,34,56, 25,6,15, 0,0));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(0,0,0, 0,0,0, 0,1,1, 12,34,56, 25,6,15, 0,0));
        tv.push_back(mk(1,0,1, 0,0,0, 25,7,4,  12,34,57, 25,7,4, 0,0));
        tv.push_back(mk(0,1,0, 23,59,59, 0,1,1, 23,59,59, 25,7,4, 0,0));
        tv.push_back(mk(1,0,1, 0,0,0, 30,1,10, 0,0,0, 30,1,10, 1,0));
        tv.push_back(mk(1,0,0, 0,0,0, 0,1,1,   0,0,1, 30,1,10, 0,0));
        tv.push_back(mk(1,0,1, 0,0,0, 25,2,29, 0,0,2,
`ifdef RTC_LEAP_YEAR_EN
                        30,1,10, 0,1));
`else
                        30,1,10, 0,1));
`endif
        tv.push_back(mk(1,0,1, 0,0,0, 28,2,29, 0,0,3,
`ifdef RTC_LEAP_YEAR_EN
                        28,2,29, 0,0));
`else
                        30,1,10, 0,1));
`endif

        foreach (tv[i]) begin
            drive(tv[i].run, tv[i].st, tv[i].sd,
                  tv[i].sh, tv[i].smi, tv[i].ss,
                  tv[i].sy, tv[i].smo, tv[i].sdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  tv[i].eh, tv[i].emi, tv[i].es,
                  tv[i].ey, tv[i].emo, tv[i].edy,
                  tv[i].ew, tv[i].ee);
        end

        // async reset while counting from 10:20:30
        drive(1, 1, 0, 10, 20, 30, 0, 1, 1);
        @(posedge clk);
        #1;
        check("load_10_20_30", 10, 20, 30, 30, 1, 10, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        check("count_10_20_31", 10, 20, 31, 30, 1, 10, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 0, 0, 0, 24, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        check("reset_held", 0, 0, 0, 24, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume_after_reset", 0, 0, 1, 24, 1, 1, 0, 0);

        model_reset();
        model_step(1, 0, 0, 0, 0, 0, 0, 1, 1);

        for (int c = 0; c < 600; c++) begin
            bit run, st, sd;
            int sh, smi, ss, sy, smo, sdy;
            run = ($urandom % 4) != 0;
            st  = ($urandom % 5) == 0;
            sd  = ($urandom % 5) == 0;
            sh  = $urandom_range(0, 25);
            smi = $urandom_range(0, 63);
            ss  = $urandom_range(0, 63);
            sy  = $urandom_range(0, 127);
            smo = $urandom_range(0, 15);
            sdy = $urandom_range(0, 31);
            if ($urandom % 3 == 0) begin
                sh = 23; smi = 59; ss = $urandom_range(50, 59);
            end
            if ($urandom % 2 == 0) begin
                sy  = $urandom_range(0, 99);
                smo = $urandom_range(1, 12);
                sdy = mlen(smo, sy) - $urandom_range(0, 1);
            end
            if ($urandom % 4 == 0 && smo == 2)
                sdy = 29;
            drive(run, st, sd, sh, smi, ss, sy, smo, sdy);
            @(posedge clk);
            #1;
            model_step(run, st, sd, sh, smi, ss, sy, smo, sdy);
            check($sformatf("rand%0d", c), mh, mm, ms, my, mmo, md, mw, me);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_calendar_counter.md
Name: rtc_calendar_counter

Overview:
- Time-of-day and calendar counter advancing once per clk_1Hz edge.
- Produces hours/minutes/seconds and year/month/day in binary.
- Feeds the six-digit multiplexed seven-segment display stage directly.
- Supports synchronous user load of time and date groups.

Parameters:
- RST_HOUR, 0, hours value after reset (0..23)
- RST_MIN, 0, minutes value after reset (0..59)
- RST_SEC, 0, seconds value after reset (0..59)
- RST_YEAR, 24, year after reset (0..99, meaning 2000+year)
- RST_MONTH, 1, month after reset (1..12)
- RST_DAY, 1, day after reset (1..31, must be valid for RST_MONTH)

Ports:
- clk_1Hz  in  1  one-second tick clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  1 = count; 0 = hold all fields (loads still honoured)
- set_time  in  1  load set_hours/set_minutes/set_seconds on this edge
- set_date  in  1  load set_year/set_month/set_day on this edge
- set_hours  in  5  load value, 0..23
- set_minutes  in  6  load value, 0..59
- set_seconds  in  6  load value, 0..59
- set_year  in  7  load value, 0..99
- set_month  in  4  load value, 1..12
- set_day  in  5  load value, 1..month length
- hours  out  5  current hour, 0..23
- minutes  out  6  current minute, 0..59
- seconds  out  6  current second, 0..59
- year  out  7  current year, 0..99
- month  out  4  current month, 1..12
- day  out  5  current day, 1..31
- day_wrap  out  1  one-cycle pulse; counting carried 23:59:59 into 00:00:00
- load_err  out  1  one-cycle pulse; a requested load was rejected

Behaviour:
- Reset: all fields take their RST_* values; day_wrap=0; load_err=0.
- All outputs are registered and update only on posedge clk_1Hz.
- Count chain (when run=1):
  - seconds 59->0 carries into minutes.
  - minutes 59->0 carries into hours.
  - hours 23->0 carries into day and pulses day_wrap.
  - day wraps from the month length to 1 and carries into month.
  - month 12->1 carries into year.
  - year 99->0 with no further carry.
- Month length: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February per the Optional Feature.
- Load validation:
  - Time group is valid only if hours<=23, minutes<=59 and seconds<=59.
  - Date group is valid only if year<=99, month 1..12, and day 1..length(set_month, set_year).
  - An invalid group is not loaded and pulses load_err; the fields it would have loaded behave as if that set_* input were low.
- Valid set_time:
  - Time fields take the load values; no increment that edge.
  - Date fields increment only if a valid set_date is also present (then the date load applies); otherwise the date holds.
- Valid set_date without set_time:
  - Date takes the load values.
  - Time counts normally if run=1.
  - Any day carry from the time chain on that edge is discarded, so the loaded date wins.
  - day_wrap still pulses if the time wrapped.
- run=0 with no loads: all fields hold; day_wrap=0.
- day_wrap and load_err are 0 on every edge where their condition is absent.
- Reset asserted mid-count overrides everything immediately (asynchronously); counting resumes on the first clk_1Hz edge after rst deasserts.

Optional Feature:
- Macro: RTC_LEAP_YEAR_EN.
- Defined: February has 29 days when year[1:0]==0 (year 0 = 2000 is a leap year), otherwise 28. Date-load validation uses the same rule.
- Undefined: February is always 28 days; a load of day 29 in February pulses load_err.

Test Plan:
- Reset with default parameters -> 00:00:00, 24-01-01, day_wrap=0, load_err=0; then 3 edges with run=1 -> seconds=3.
- Load 24-02-28 23:59:59, one edge:
  - With RTC_LEAP_YEAR_EN -> 24-02-29 00:00:00, day_wrap=1.
  - Without it -> 24-03-01 00:00:00, day_wrap=1.
- Load 99-12-31 23:59:59, one edge -> 00-01-01 00:00:00; day_wrap=1 for exactly one cycle.
- set_time with hours=24 -> load_err=1 and time advances normally. Then set_date 24-04-31 -> load_err=1 and the date is unchanged.
- Simultaneous valid set_time 12:34:56 and set_date 25-06-15 -> exactly those values next cycle, no increment. Then run=0 for 5 edges -> values unchanged.
- Assert rst asynchronously between edges while counting at 10:20:30 -> outputs immediately take the reset values; deassert -> counting resumes from 00:00:00.
